// File: rtl/adder_pkg.sv
// Shared constants and elaboration helpers for the pipelined adder/subtractor.
package adder_pkg;

   // Bit positions of the status flags inside the packed flag vector
   localparam int unsigned FLAG_CARRY = 0;
   localparam int unsigned FLAG_OVF   = 1;
   localparam int unsigned FLAG_ZERO  = 2;
   localparam int unsigned FLAG_W     = 3;

   function automatic int unsigned chunk_width(input int unsigned width,
                                               input int unsigned stages);
      return (stages == 0) ? 0 : width / stages;
   endfunction

   // Operands must split into equal, non-empty chunks
   function automatic bit split_ok(input int unsigned width,
                                   input int unsigned stages);
      return (stages != 0) && (width >= stages) && ((width % stages) == 0);
   endfunction

endpackage

// File: rtl/adder_pipe_stage.sv
// One pipeline stage: CHUNK-bit ripple adder with registered sum, carry and flags.
module adder_pipe_stage #(
   parameter int unsigned CHUNK = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en_i,
   input  logic             valid_i,
   input  logic [CHUNK-1:0] a_i,
   input  logic [CHUNK-1:0] b_i,
   input  logic             c_i,
   input  logic             zero_i,
   output logic [CHUNK-1:0] sum_o,
   output logic             c_o,
   output logic             ovf_o,
   output logic             zero_o,
   output logic             valid_o
);

   logic [CHUNK:0]   carry;
   logic [CHUNK-1:0] sum_d;
   logic             c_d;
   logic             ovf_d;
   logic             zero_d;

   logic [CHUNK-1:0] sum_q;
   logic             c_q;
   logic             ovf_q;
   logic             zero_q;
   logic             valid_q;

   assign carry[0] = c_i;

   for (genvar i = 0; i < CHUNK; i++) begin : g_bit
      full_adder_dataflow u_fa (
         .a_i     (a_i[i]),
         .b_i     (b_i[i]),
         .c_i     (carry[i]),
         .sum_c   (sum_d[i]),
         .carry_c (carry[i+1])
      );
   end

   // Overflow only matters on the top stage; zero accumulates across chunks
   assign c_d    = carry[CHUNK];
   assign ovf_d  = carry[CHUNK] ^ carry[CHUNK-1];
   assign zero_d = zero_i && (sum_d == '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sum_q   <= '0;
         c_q     <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
         valid_q <= 1'b0;
      end else if (en_i) begin
         sum_q   <= sum_d;
         c_q     <= c_d;
         ovf_q   <= ovf_d;
         zero_q  <= zero_d;
         valid_q <= valid_i;
      end
   end

   assign sum_o   = sum_q;
   assign c_o     = c_q;
   assign ovf_o   = ovf_q;
   assign zero_o  = zero_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/full_adder_dataflow.sv
// Single-bit dataflow full adder used as the ripple cell of each stage.
module full_adder_dataflow (
   input  logic a_i,
   input  logic b_i,
   input  logic c_i,
   output logic sum_c,
   output logic carry_c
);

   assign sum_c   = a_i ^ b_i ^ c_i;
   assign carry_c = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/pipelined_adder_subtractor.sv
// Pipelined two's-complement adder/subtractor with carry-per-stage registers,
// operand skew / sum deskew, status flags and a globally stalled valid/ready handshake.
module pipelined_adder_subtractor
   import adder_pkg::*;
#(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned STAGES = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             mode_sub,
   input  logic             carry_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out,
   output logic             overflow,
   output logic             zero
);

   localparam int unsigned CHUNK = chunk_width(WIDTH, STAGES);

   if (!split_ok(WIDTH, STAGES)) begin : g_param_check
      $fatal(1, "pipelined_adder_subtractor: WIDTH must be a non-zero multiple of STAGES");
   end

   logic             advance;
   logic [WIDTH-1:0] b_adj;
   logic             cin_adj;

   logic [STAGES-1:0][CHUNK-1:0] st_a;
   logic [STAGES-1:0][CHUNK-1:0] st_b;
   logic [STAGES-1:0][CHUNK-1:0] st_sum;
   logic [STAGES-1:0]            st_cin;
   logic [STAGES-1:0]            st_cout;
   logic [STAGES-1:0]            st_zin;
   logic [STAGES-1:0]            st_zout;
   logic [STAGES-1:0]            st_ovf;
   logic [STAGES-1:0]            st_vin;
   logic [STAGES-1:0]            st_vout;
   logic [FLAG_W-1:0]            flags;
   logic                         unused_ovf_c;

   // Global stall: every register moves only when the output slot can drain
   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;

   // Subtract is a + ~b + ~borrow_in
   assign b_adj   = mode_sub ? ~b : b;
   assign cin_adj = carry_in ^ mode_sub;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      if (k == 0) begin : g_head
         assign st_a[0]   = a[CHUNK-1:0];
         assign st_b[0]   = b_adj[CHUNK-1:0];
         assign st_cin[0] = cin_adj;
         assign st_zin[0] = 1'b1;
         assign st_vin[0] = in_valid;
      end else begin : g_tail
         assign st_a[k]   = g_skew[k].a_q[CHUNK-1:0];
         assign st_b[k]   = g_skew[k].b_q[CHUNK-1:0];
         assign st_cin[k] = st_cout[k-1];
         assign st_zin[k] = st_zout[k-1];
         assign st_vin[k] = st_vout[k-1];
      end

      adder_pipe_stage #(
         .CHUNK (CHUNK)
      ) u_stage (
         .clk     (clk),
         .reset   (reset),
         .en_i    (advance),
         .valid_i (st_vin[k]),
         .a_i     (st_a[k]),
         .b_i     (st_b[k]),
         .c_i     (st_cin[k]),
         .zero_i  (st_zin[k]),
         .sum_o   (st_sum[k]),
         .c_o     (st_cout[k]),
         .ovf_o   (st_ovf[k]),
         .zero_o  (st_zout[k]),
         .valid_o (st_vout[k])
      );
   end

   // Skew level j holds operand chunks j..STAGES-1, aligned with stage j's inputs
   for (genvar j = 1; j < STAGES; j++) begin : g_skew
      localparam int unsigned UW = (STAGES - j) * CHUNK;
      logic [UW-1:0] a_d;
      logic [UW-1:0] b_d;
      logic [UW-1:0] a_q;
      logic [UW-1:0] b_q;

      if (j == 1) begin : g_first
         assign a_d = a[WIDTH-1:CHUNK];
         assign b_d = b_adj[WIDTH-1:CHUNK];
      end else begin : g_next
         assign a_d = g_skew[j-1].a_q[UW+CHUNK-1:CHUNK];
         assign b_d = g_skew[j-1].b_q[UW+CHUNK-1:CHUNK];
      end

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            a_q <= '0;
            b_q <= '0;
         end else if (advance) begin
            a_q <= a_d;
            b_q <= b_d;
         end
      end
   end

   // Deskew level j holds finished sum chunks 0..j-1, aligned with stage j's outputs
   for (genvar j = 1; j < STAGES; j++) begin : g_dsk
      localparam int unsigned DW = j * CHUNK;
      logic [DW-1:0] d;
      logic [DW-1:0] q;

      if (j == 1) begin : g_first
         assign d = st_sum[0];
      end else begin : g_next
         assign d = {st_sum[j-1], g_dsk[j-1].q};
      end

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            q <= '0;
         end else if (advance) begin
            q <= d;
         end
      end
   end

   if (STAGES == 1) begin : g_out_single
      assign sum = st_sum[0];
   end else begin : g_out_multi
      assign sum = {st_sum[STAGES-1], g_dsk[STAGES-1].q};
   end

   // Flags come straight from the last stage's registers
   assign flags[FLAG_CARRY] = st_cout[STAGES-1];
   assign flags[FLAG_OVF]   = st_ovf[STAGES-1];
   assign flags[FLAG_ZERO]  = st_zout[STAGES-1];

   // Lower stages' overflow bits have no meaning for the full word
   assign unused_ovf_c = ^st_ovf;

   assign out_valid = st_vout[STAGES-1];
   assign carry_out = flags[FLAG_CARRY];
   assign overflow  = flags[FLAG_OVF];
   assign zero      = flags[FLAG_ZERO];

endmodule

// File: tb/tb_pipelined_adder_subtractor.sv
// Self-checking bench: cycle-level reference model compared every cycle,
// plus directed literal checks for latency, flags, stall and async reset.
module tb_pipelined_adder_subtractor;

   localparam int unsigned W = 16;
   localparam int unsigned S = 4;

   logic         clk;
   logic         reset;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         mode_sub;
   logic         carry_in;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         carry_out;
   logic         overflow;
   logic         zero;

   int checks = 0;
   int passes = 0;

   typedef struct {
      logic         v;
      logic [W-1:0] s;
      logic         c;
      logic         o;
      logic         z;
   } exp_t;

   exp_t pipe [S];

   pipelined_adder_subtractor #(
      .WIDTH  (W),
      .STAGES (S)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .mode_sub  (mode_sub),
      .carry_in  (carry_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .carry_out (carry_out),
      .overflow  (overflow),
      .zero      (zero)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      else passes++;
   endtask

   function automatic exp_t blank();
      exp_t r;
      r.v = 1'b0; r.s = '0; r.c = 1'b0; r.o = 1'b0; r.z = 1'b0;
      return r;
   endfunction

   // Arithmetic meaning: signed result out of range => overflow; unsigned no-borrow => carry
   function automatic exp_t ref_model(input logic [W-1:0] x, input logic [W-1:0] y,
                                      input logic sub, input logic ci);
      exp_t   r;
      longint sx, sy, sr, ux, uy, ur;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = longint'(x);
      uy = longint'(y);
      if (!sub) begin
         ur  = ux + uy + longint'(ci);
         sr  = sx + sy + longint'(ci);
         r.c = (ur >= (longint'(1) << W));
      end else begin
         ur  = ux - uy - longint'(ci);
         sr  = sx - sy - longint'(ci);
         r.c = (ur >= 0);
      end
      r.v = 1'b1;
      r.s = W'(ur);
      r.o = (sr > ((longint'(1) << (W-1)) - 1)) || (sr < -(longint'(1) << (W-1)));
      r.z = (r.s == '0);
      return r;
   endfunction

   // Every-cycle comparison against the model, then advance the model
   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         for (int i = 0; i < S; i++) pipe[i] = blank();
      end else begin
         e = pipe[S-1];
         check("out_valid", 32'(out_valid), 32'(e.v));
         check("in_ready", 32'(in_ready), 32'(!e.v || out_ready));
         if (e.v) begin
            check("sum", 32'(sum), 32'(e.s));
            check("carry_out", 32'(carry_out), 32'(e.c));
            check("overflow", 32'(overflow), 32'(e.o));
            check("zero", 32'(zero), 32'(e.z));
         end
         if (!e.v || out_ready) begin
            for (int i = S-1; i > 0; i--) pipe[i] = pipe[i-1];
            pipe[0] = in_valid ? ref_model(a, b, mode_sub, carry_in) : blank();
         end
      end
   end

   // One vector into an empty pipeline; checks latency and literal results
   task automatic directed(input string nm, input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic sub, input logic ci, input logic [W-1:0] es,
                           input logic ec, input logic eo, input logic ez);
      int n;
      n = 0;
      in_valid = 1'b1; a = x; b = y; mode_sub = sub; carry_in = ci;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         if (out_valid === 1'b1) begin
            n = i;
            break;
         end
      end
      check({nm, "_latency"}, 32'(n), 32'(S));
      check({nm, "_sum"}, 32'(sum), 32'(es));
      check({nm, "_carry"}, 32'(carry_out), 32'(ec));
      check({nm, "_ovf"}, 32'(overflow), 32'(eo));
      check({nm, "_zero"}, 32'(zero), 32'(ez));
      @(posedge clk); #1;
   endtask

   // Present a vector and hold it until the block accepts it
   task automatic send(input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic sub, input logic ci);
      logic acc;
      acc = 1'b0;
      in_valid = 1'b1; a = x; b = y; mode_sub = sub; carry_in = ci;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk); #1;
         if (acc) break;
      end
      if (!acc) check("send_timeout", 32'(acc), 32'd1);
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; a = '0; b = '0;
      mode_sub = 1'b0; carry_in = 1'b0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_sum", 32'(sum), 32'd0);
      check("rst_flags", 32'({carry_out, overflow, zero}), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      reset = 1'b0;
      @(posedge clk); #1;

      directed("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
      directed("add_ovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
      directed("sub_ovf",  16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0);
      directed("sub_brw",  16'h0000, 16'h0001, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0);
      directed("sub_bin",  16'h0005, 16'h0005, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);
      directed("add_cin",  16'h0000, 16'hFFFF, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);

      // Alternating bubbles: a result every other cycle, each S cycles after issue
      for (int i = 0; i < 12; i++) begin
         in_valid = (i < 8) && ((i % 2) == 0);
         a = 16'h1234; b = 16'h4321; mode_sub = 1'b0; carry_in = 1'b1;
         @(negedge clk);
         if (i >= S) begin
            check("alt_valid", 32'(out_valid), 32'(((i - S) % 2) == 0));
            if (((i - S) % 2) == 0) begin
               check("alt_sum", 32'(sum), 32'h5556);
               check("alt_carry", 32'(carry_out), 32'd0);
            end
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      repeat (S + 2) @(posedge clk);
      #1;

      // Back-to-back stream with a three-cycle consumer stall in the middle
      fork
         begin
            for (int i = 0; i < 8; i++)
               send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
            in_valid = 1'b0;
         end
         begin
            repeat (6) @(posedge clk);
            #1 out_ready = 1'b0;
            @(negedge clk);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            repeat (3) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      repeat (S + 4) @(posedge clk);
      #1;

      // Random traffic with random backpressure
      for (int i = 0; i < 400; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         a         = W'($urandom);
         b         = W'($urandom);
         mode_sub  = 1'($urandom);
         carry_in  = 1'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         @(posedge clk); #1;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (S + 4) @(posedge clk);
      #1;

      // Mid-stream asynchronous reset flushes everything in flight
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; a = 16'h00F0 + W'(i); b = 16'h0101; mode_sub = 1'b0; carry_in = 1'b0;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      check("pre_rst_valid", 32'(out_valid), 32'd1);
      #2 reset = 1'b1;
      #1;
      check("arst_out_valid", 32'(out_valid), 32'd0);
      check("arst_sum", 32'(sum), 32'd0);
      check("arst_flags", 32'({carry_out, overflow, zero}), 32'd0);
      check("arst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #3 reset = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready", 32'(in_ready), 32'd1);
      repeat (S + 6) @(posedge clk);
      #1;

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
